// File: rtl/mac_rx_frame_filter.sv
// rtl/mac_rx_frame_filter.sv - speculative RX byte buffer; commits good IPv4/ARP frames and replays them.
// Optional drop/good counters are built when RX_FILTER_STAT_EN is defined.
module mac_rx_frame_filter #(
  parameter int P_ADDR_W = 11,
  parameter int P_DESC_W = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_type,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic        i_crc_valid,
  input  logic        i_crc_error,
  output logic [7:0]  o_ip_data,
  output logic        o_ip_valid,
  output logic        o_ip_last,
  output logic [7:0]  o_arp_data,
  output logic        o_arp_valid,
  output logic        o_arp_last,
`ifdef RX_FILTER_STAT_EN
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_good_cnt,
`endif
  output logic        o_drop
);

  localparam int DEPTH = 1 << P_ADDR_W;
  localparam int NDESC = 1 << P_DESC_W;
  localparam logic [P_ADDR_W-1:0] A_ONE = 1;
  localparam logic [P_ADDR_W:0]   L_ONE = 1;
  localparam logic [P_DESC_W-1:0] D_ONE = 1;
  localparam logic [P_DESC_W:0]   C_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_SEND} state_t;

  logic [7:0]          buf_mem  [DEPTH];
  logic [P_ADDR_W+1:0] desc_mem [NDESC];

  logic [P_ADDR_W-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [P_ADDR_W:0]   len;
  logic                ovf, in_frame, pending, drop_q;

  logic                first, full, do_write, type_ok, is_arp_in, commit, discard;
  logic [P_ADDR_W-1:0] base_ptr, ptr_inc, wr_ptr_n;
  logic [P_ADDR_W:0]   base_len, len_n;
  logic                base_ovf, ovf_n;

  logic [P_DESC_W-1:0] dw_ptr, dr_ptr;
  logic [P_DESC_W:0]   d_cnt;
  logic                desc_full, desc_empty;
  logic [P_ADDR_W+1:0] desc_rd;

  state_t              state_q, state_d;
  logic                pop, rd_en, arp_q, send;
  logic [P_ADDR_W:0]   cnt;
  logic [7:0]          rd_data;

  // A new frame always restarts at the committed pointer, which also
  // performs the implicit rollback of a frame still awaiting its verdict.
  assign first     = i_valid && !in_frame;
  assign base_ptr  = first ? cm_ptr : wr_ptr;
  assign base_len  = first ? '0 : len;
  assign base_ovf  = first ? 1'b0 : ovf;
  assign ptr_inc   = base_ptr + A_ONE;
  assign full      = (ptr_inc == rd_ptr);
  assign do_write  = i_valid && !full;
  assign wr_ptr_n  = do_write ? ptr_inc : base_ptr;
  assign len_n     = do_write ? base_len + L_ONE : base_len;
  assign ovf_n     = base_ovf || (i_valid && full);

  assign is_arp_in = (i_type == 16'h0806);
  assign type_ok   = (i_type == 16'h0800) || is_arp_in;
  assign commit    = i_crc_valid && !i_crc_error && !ovf_n && type_ok &&
                     (len_n != '0) && !desc_full;
  assign discard   = (i_crc_valid && !commit) || (first && pending);

  always_ff @(posedge i_clk) begin
    if (do_write) buf_mem[base_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      len      <= '0;
      ovf      <= 1'b0;
      in_frame <= 1'b0;
      pending  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= discard;
      if (i_crc_valid) begin
        wr_ptr   <= commit ? wr_ptr_n : cm_ptr;
        if (commit) cm_ptr <= wr_ptr_n;
        len      <= '0;
        ovf      <= 1'b0;
        in_frame <= 1'b0;
        pending  <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr_n;
        len    <= len_n;
        ovf    <= ovf_n;
        if (i_valid) begin
          in_frame <= !i_last;
          pending  <= i_last;
        end
      end
    end
  end

  assign desc_full  = d_cnt[P_DESC_W];
  assign desc_empty = (d_cnt == '0);
  assign desc_rd    = desc_mem[dr_ptr];

  always_ff @(posedge i_clk) begin
    if (commit) desc_mem[dw_ptr] <= {is_arp_in, len_n};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dw_ptr <= '0;
      dr_ptr <= '0;
      d_cnt  <= '0;
    end else begin
      if (commit) dw_ptr <= dw_ptr + D_ONE;
      if (pop)    dr_ptr <= dr_ptr + D_ONE;
      case ({commit, pop})
        2'b10:   d_cnt <= d_cnt + C_ONE;
        2'b01:   d_cnt <= d_cnt - C_ONE;
        default: d_cnt <= d_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // rd_ptr runs one byte ahead of the output; it stops on the final byte so
  // it ends exactly at the start of the next committed frame.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: if (!desc_empty) state_d = S_POP;
      S_POP: begin
        pop     = 1'b1;
        rd_en   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cnt == L_ONE) state_d = S_IDLE;
        else              rd_en   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rd_en) rd_data <= buf_mem[rd_ptr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      cnt    <= '0;
      arp_q  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + A_ONE;
      if (pop) begin
        cnt   <= desc_rd[P_ADDR_W:0];
        arp_q <= desc_rd[P_ADDR_W+1];
      end else if (state_q == S_SEND) begin
        cnt <= cnt - L_ONE;
      end
    end
  end

  assign send        = (state_q == S_SEND);
  assign o_ip_valid  = send && !arp_q;
  assign o_ip_last   = o_ip_valid && (cnt == L_ONE);
  assign o_ip_data   = o_ip_valid ? rd_data : 8'h00;
  assign o_arp_valid = send && arp_q;
  assign o_arp_last  = o_arp_valid && (cnt == L_ONE);
  assign o_arp_data  = o_arp_valid ? rd_data : 8'h00;
  assign o_drop      = drop_q;

`ifdef RX_FILTER_STAT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
      o_good_cnt <= '0;
    end else begin
      if (discard && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      if (commit && o_good_cnt != 16'hFFFF)  o_good_cnt <= o_good_cnt + 16'd1;
    end
  end
`endif

endmodule
